periph_bus_master: RTL and testbench
====================================

Name: periph_bus_master

Overview:
- Bus initiator for the 4-bit-address peripheral bus (A/WD/WE out, RD in), replacing the CPU as the bus driver for debug/bring-up and automated sequences.
- Accepts commands on a valid/ready port, executes single READ, WRITE or POLL transactions against the peripheral decoder, and returns a response on a valid/ready port.
- POLL repeatedly reads one address until a masked compare matches or a retry budget runs out.

Parameters:
- POLL_TIMEOUT, 1024: maximum POLL read attempts before giving up; minimum 1.
- POLL_GAP, 4: idle cycles between consecutive POLL reads; 0 means back-to-back reads.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_op  in  2  operation: 0 READ, 1 WRITE, 2 POLL, 3 reserved
- cmd_addr  in  4  peripheral address
- cmd_wdata  in  32  WRITE data, or POLL compare value
- cmd_mask  in  32  POLL compare mask; ignored otherwise
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_data  out  32  read data, or echoed write data
- rsp_status  out  2  response status: 0 OK, 1 TIMEOUT, 2 BADOP
- A  out  4  bus address
- WD  out  32  bus write data
- WE  out  1  bus write strobe, one cycle per write
- RD  in  32  bus read data, combinational from the slave for the current A

Behaviour:
- Reset: the reset edge with rst_n=0 puts the FSM in IDLE and clears the poll counter and gap counter. Outputs after reset:
  - cmd_ready=1
  - rsp_valid=0, rsp_data=0, rsp_status=0
  - A=0, WD=0, WE=0
- Reset mid-transaction abandons the transaction: no response is produced and WE is 0 from the first reset cycle onward.
- All outputs are registered.
- FSM states: IDLE, ISSUE, GAP, RESP.
- IDLE:
  - cmd_ready=1, A=0, WD=0, WE=0.
  - On cmd_valid&&cmd_ready the command is latched, with cmd_ready=0 from the next cycle.
  - Ops 0/1/2 go to ISSUE. Op 3 goes directly to RESP with status BADOP and rsp_data=0; no bus access occurs.
- ISSUE (exactly one cycle per access):
  - A=addr.
  - WRITE: WD=wdata, WE=1. Next state RESP with rsp_data=wdata, status OK.
  - READ: WE=0, RD sampled at the end of this cycle. Next state RESP with rsp_data=RD, status OK.
  - POLL: WE=0, RD sampled and the attempt counter incremented.
    - (RD & mask)==(wdata & mask): RESP, rsp_data=RD, OK.
    - Otherwise, if attempts==POLL_TIMEOUT: RESP, rsp_data=last RD, TIMEOUT.
    - Otherwise: GAP, or ISSUE again if POLL_GAP=0.
  - mask=0 matches on the first read.
- GAP: A held at addr, WE=0. Lasts POLL_GAP cycles, then ISSUE.
- RESP:
  - rsp_valid=1; rsp_data and rsp_status stable until the handshake.
  - On rsp_valid&&rsp_ready: rsp_valid=0 on the next cycle and the FSM returns to IDLE. cmd_ready=1 from that cycle.
  - No new command is accepted while a response is pending.
- Latency, with acceptance at edge N:
  - Bus cycle occupies cycle N+1.
  - rsp_valid rises at N+2.
  - The next command is accepted no earlier than 1 cycle after the response handshake.
- A POLL that matches on attempt k: rsp_valid rises 2 + (k-1)*(POLL_GAP+1) cycles after acceptance.
- WE is never asserted for READ, POLL or BADOP. WE is high for exactly one cycle per WRITE.
- Attempt counter width: clog2(POLL_TIMEOUT)+1 bits. It saturates at POLL_TIMEOUT and is cleared on acceptance of each command.
- cmd_* inputs are ignored when cmd_ready=0. rsp_ready is ignored when rsp_valid=0.

Test Plan:
- WRITE addr=4, wdata=0x0000_0015 -> exactly one cycle with A=4, WD=0x15, WE=1; then rsp_valid with rsp_data=0x15, status 0.
- READ addr=0 with the slave model returning 0x0000_0A3C -> A=0 for one cycle, WE=0, rsp_data=0x0A3C, status 0; rsp_valid rises 2 cycles after acceptance.
- POLL addr=8, mask=0x1, wdata=0x1, RD bit0 set on the 3rd read, POLL_GAP=4 -> 3 reads spaced 5 cycles apart, rsp_data has bit0=1, status 0, rsp_valid 12 cycles after acceptance.
- POLL with POLL_TIMEOUT=8 and RD never matching (RD=0x0, mask=0xFF, wdata=0x5A) -> exactly 8 reads, status 1 (TIMEOUT), rsp_data=0x0.
- cmd_op=3 -> no A change, WE never 1, status 2, rsp_data=0. Also hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stay stable and cmd_ready stays 0 throughout.
- Assert rst_n=0 during the GAP of a POLL -> next cycle cmd_ready=1, A=0, WE=0, rsp_valid=0, and no response is produced. A following READ completes normally.

Source files
------------

// File: rtl/periph_bus_master.sv
// periph_bus_master: peripheral bus initiator running READ/WRITE/POLL commands (cmd_* in, rsp_* out, A/WD/WE/RD bus)
module periph_bus_master #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [3:0]  A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);
  localparam int CW = $clog2(POLL_TIMEOUT) + 1;
  localparam int GW = $clog2(POLL_GAP + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;
  state_t state;
  logic [1:0] op;
  logic [3:0] addr;
  logic [31:0] wdata, mask;
  logic [CW-1:0] att, att_nx;
  logic [GW-1:0] gap_cnt;
  logic hit;
  always_comb begin
    att_nx = (att == CW'(POLL_TIMEOUT)) ? att : att + 1'b1;
    hit = ((RD ^ wdata) & mask) == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_status <= '0;
      A <= '0;
      WD <= '0;
      WE <= 1'b0;
      att <= '0;
      gap_cnt <= '0;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      mask <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          op <= cmd_op;
          addr <= cmd_addr;
          wdata <= cmd_wdata;
          mask <= cmd_mask;
          att <= '0;
          gap_cnt <= '0;
          if (cmd_op == 2'd3) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_data <= '0;
            rsp_status <= 2'd2;
          end else begin
            state <= ISSUE;
            A <= cmd_addr;
            WD <= (cmd_op == 2'd1) ? cmd_wdata : '0;
            WE <= cmd_op == 2'd1;
          end
        end
        ISSUE: begin
          WE <= 1'b0;
          WD <= '0;
          if (op == 2'd2) begin
            att <= att_nx;
            if (hit || att_nx == CW'(POLL_TIMEOUT)) begin
              state <= RESP;
              rsp_valid <= 1'b1;
              rsp_data <= RD;
              rsp_status <= hit ? 2'd0 : 2'd1;
              A <= '0;
            end else if (POLL_GAP != 0) begin
              state <= GAP;
              gap_cnt <= '0;
            end
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_data <= (op == 2'd1) ? wdata : RD;
            rsp_status <= 2'd0;
            A <= '0;
          end
        end
        GAP: if (gap_cnt == GW'(POLL_GAP - 1)) begin
          state <= ISSUE;
          gap_cnt <= '0;
        end else gap_cnt <= gap_cnt + 1'b1;
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: table-driven, hand-sequenced and randomized checks of periph_bus_master
module tb_periph_bus_master;
  localparam int TO = 8;
  localparam int GP = 4;
  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, WE;
  logic [1:0] cmd_op, rsp_status;
  logic [3:0] cmd_addr, A;
  logic [31:0] cmd_wdata, cmd_mask, rsp_data, WD, RD, rd_new;
  logic [31:0] mem [16];
  int rel, sw;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [31:0] wdata, mask, rd_old, rd_new;
    int sw, dly;
    logic [31:0] e_data;
    logic [1:0] e_st;
    int e_lat, e_we;
  } vec_t;
  vec_t tbl [7];
  assign RD = (rel >= sw) ? rd_new : mem[A];
  always #5 clk = ~clk;
  periph_bus_master #(.POLL_TIMEOUT(TO), .POLL_GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .A(A), .WD(WD), .WE(WE), .RD(RD)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wdata, mask,
                              rd_old, rdn, input int s, d, input logic [31:0] ed, input logic [1:0] es,
                              input int el, ew);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.mask = mask; v.rd_old = rd_old; v.rd_new = rdn;
    v.sw = s; v.dly = d; v.e_data = ed; v.e_st = es; v.e_lat = el; v.e_we = ew;
    return v;
  endfunction
  // Reference: reads happen at cycle 1 + (j-1)*(GP+1) after acceptance; the slave
  // returns rd_new from cycle sw onward, otherwise rd_old.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    logic [31:0] val;
    int r;
    v.e_we = (v.op == 2'd1) ? 1 : 0;
    v.e_data = '0;
    v.e_st = 2'd0;
    v.e_lat = 2;
    if (v.op == 2'd3) begin
      v.e_st = 2'd2;
      v.e_lat = 1;
    end else if (v.op == 2'd1) v.e_data = v.wdata;
    else if (v.op == 2'd0) v.e_data = (1 >= v.sw) ? v.rd_new : v.rd_old;
    else begin
      v.e_st = 2'd1;
      for (int j = 1; j <= TO; j++) begin
        r = 1 + (j - 1) * (GP + 1);
        val = (r >= v.sw) ? v.rd_new : v.rd_old;
        v.e_data = val;
        v.e_lat = r + 1;
        if ((val & v.mask) == (v.wdata & v.mask)) begin
          v.e_st = 2'd0;
          break;
        end
      end
    end
    return v;
  endfunction
  task automatic scramble;
    cmd_valid = 1'($urandom);
    cmd_op = 2'($urandom);
    cmd_addr = 4'($urandom);
    cmd_wdata = $urandom;
    cmd_mask = $urandom;
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int lat = 0;
    int wec = 0;
    logic busok = 1'b1;
    logic abad = 1'b0;
    logic rbad = 1'b0;
    logic [31:0] d;
    logic [1:0] s;
    mem[v.addr] = v.rd_old;
    rd_new = v.rd_new;
    sw = v.sw;
    rel = 0;
    cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_mask = v.mask; cmd_valid = 1'b1;
    chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      rel = lat;
      scramble();
      wec += int'(WE);
      if (WE && (A !== v.addr || WD !== v.wdata)) busok = 1'b0;
      if (lat == 1 && v.op != 2'd3 && A !== v.addr) busok = 1'b0;
      if (v.op == 2'd3 && A !== 4'd0) abad = 1'b1;
      if (cmd_ready !== 1'b0) rbad = 1'b1;
      if (rsp_valid === 1'b1) break;
      rsp_ready = 1'($urandom);
    end
    rsp_ready = 1'b0;
    chk({nm, "_latency"}, lat, v.e_lat);
    chk({nm, "_data"}, rsp_data, v.e_data);
    chk({nm, "_status"}, {30'd0, rsp_status}, {30'd0, v.e_st});
    chk({nm, "_we_cycles"}, wec, v.e_we);
    chk({nm, "_bus"}, {31'd0, busok}, 32'd1);
    chk({nm, "_busy"}, {31'd0, rbad}, 32'd0);
    if (v.op == 2'd3) chk({nm, "_badop_addr"}, {31'd0, abad}, 32'd0);
    d = rsp_data;
    s = rsp_status;
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clk);
      scramble();
      chk({nm, "_hold_ctl"}, {28'd0, rsp_valid, cmd_ready, rsp_status}, {28'd0, 2'b10, s});
      chk({nm, "_hold_data"}, rsp_data, d);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_idle"}, {25'd0, rsp_valid, cmd_ready, WE, A}, {25'd0, 3'b010, 4'd0});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    logic seen;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rel = 0; sw = 1000; rd_new = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    tbl[0] = mk(2'd1, 4'd4, 32'h15, 32'h0, 32'h0, 32'h0, 1000, 0, 32'h15, 2'd0, 2, 1);
    tbl[1] = mk(2'd0, 4'd0, 32'h0, 32'h0, 32'h0A3C, 32'h0, 1000, 2, 32'h0A3C, 2'd0, 2, 0);
    tbl[2] = mk(2'd2, 4'd8, 32'h1, 32'h1, 32'hFFFF_FFFE, 32'h101, 9, 1, 32'h101, 2'd0, 12, 0);
    tbl[3] = mk(2'd2, 4'd2, 32'h5A, 32'hFF, 32'h0, 32'h0, 1000, 0, 32'h0, 2'd1, 37, 0);
    tbl[4] = mk(2'd3, 4'd7, 32'hAAAA, 32'h0, 32'h0, 32'h0, 1000, 5, 32'h0, 2'd2, 1, 0);
    tbl[5] = mk(2'd2, 4'd3, 32'h1234, 32'h0, 32'hDEAD, 32'h0, 1000, 0, 32'hDEAD, 2'd0, 2, 0);
    tbl[6] = mk(2'd2, 4'd9, 32'h5A, 32'hFF, 32'h11, 32'h7A5A, 33, 1, 32'h7A5A, 2'd0, 37, 0);
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp", {29'd0, rsp_valid, rsp_status}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_bus", {27'd0, WE, A}, 32'd0);
    chk("reset_wd", WD, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    mem[5] = 32'h0; sw = 1000; rel = 0;
    cmd_op = 2'd2; cmd_addr = 4'd5; cmd_wdata = 32'h3; cmd_mask = 32'hF; cmd_valid = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("gap_reset_state", {25'd0, cmd_ready, rsp_valid, WE, A}, {25'd0, 3'b100, 4'd0});
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || WE !== 1'b0) seen = 1'b1;
    end
    chk("gap_reset_no_rsp", {31'd0, seen}, 32'd0);
    run_vec(mk(2'd0, 4'd6, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 1000, 1, 32'hCAFE_F00D, 2'd0, 2, 0), "post_reset_read");
    for (int n = 0; n < 40; n++) begin
      v.op = 2'($urandom_range(0, 3));
      v.addr = 4'($urandom);
      v.wdata = $urandom;
      case ($urandom_range(0, 3))
        0: v.mask = 32'h0;
        1: v.mask = 32'd1 << $urandom_range(0, 31);
        2: v.mask = 32'hFF;
        default: v.mask = $urandom;
      endcase
      v.rd_old = $urandom;
      v.rd_new = ($urandom_range(0, 1) == 1) ? ((v.wdata & v.mask) | ($urandom & ~v.mask)) : $urandom;
      v.sw = $urandom_range(0, 45);
      v.dly = $urandom_range(0, 3);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
